// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Operand/issue stage in front of the `alu` block. Holds a small register file,
// accepts one instruction at a time over valid/ready, reads two sources, pulses
// the alu enable for one cycle, then writes the alu result back to rd and
// reports it together with the Zero flag.
//
// Ports
//   clk, rst_n                 rising-edge clock, async active-low reset
//   instr_valid/instr_ready    instruction handshake
//   instr_op/rd/rs/rt          alu op code, destination, source A, source B
//   ext_wr_en/addr/data        external register load (wins over instructions)
//   alu_A/alu_B/alu_Op         operands and op code driven to the alu
//   alu_enable                 one-cycle capture strobe for the alu
//   alu_Out/alu_Zero           alu result and zero flag
//   done                       one-cycle pulse when an instruction retires
//   err                        one-cycle pulse when an illegal op is rejected
//   result/zero_flag           last retired result and Zero
//   dbg_addr/dbg_data          combinational register-file peek
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter  int DATA_W  = 32,
  parameter  int REG_CNT = 8,
  localparam int AW      = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [AW-1:0]     instr_rd,
  input  logic [AW-1:0]     instr_rs,
  input  logic [AW-1:0]     instr_rt,
  input  logic              ext_wr_en,
  input  logic [AW-1:0]     ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [3:0]        alu_Op,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_Out,
  input  logic              alu_Zero,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2
  } state_e;

  // Op codes the alu implements; everything else is rejected with err.
  function automatic logic op_legal(input logic [3:0] op);
    logic legal;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b1000, 4'b1001, 4'b1010,
      4'b1100, 4'b1101: legal = 1'b1;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   rf_q [REG_CNT];
  logic [DATA_W-1:0]   alu_a_q, alu_b_q;
  logic [3:0]          alu_op_q;
  logic [AW-1:0]       rd_q;
  logic                done_q, err_q, zero_q;
  logic [DATA_W-1:0]   result_q;

  logic                hs_s, accept_s, reject_s;
  logic                wr_en_s;
  logic [AW-1:0]       wr_addr_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic [DATA_W-1:0]   rs_data_s, rt_data_s;

  assign hs_s     = instr_valid & instr_ready;
  assign accept_s = hs_s & op_legal(instr_op);
  assign reject_s = hs_s & ~op_legal(instr_op);

  // r0 is hard-wired to zero on every read path.
  assign rs_data_s = (instr_rs == {AW{1'b0}}) ? {DATA_W{1'b0}} : rf_q[instr_rs];
  assign rt_data_s = (instr_rt == {AW{1'b0}}) ? {DATA_W{1'b0}} : rf_q[instr_rt];
  assign dbg_data  = (dbg_addr == {AW{1'b0}}) ? {DATA_W{1'b0}} : rf_q[dbg_addr];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: illegal ops leave the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; ready is withheld during reset and while an external load owns IDLE.
  always_comb begin
    instr_ready = 1'b0;
    alu_enable  = 1'b0;
    case (state_q)
      IDLE:    instr_ready = rst_n & ~ext_wr_en;
      ISSUE:   alu_enable  = 1'b1;
      WRITE:   alu_enable  = 1'b0;
      default: begin
        instr_ready = 1'b0;
        alu_enable  = 1'b0;
      end
    endcase
  end

  // Register-file write port: external load only in IDLE, writeback only in WRITE.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = {AW{1'b0}};
    wr_data_s = {DATA_W{1'b0}};
    case (state_q)
      IDLE: begin
        wr_en_s   = ext_wr_en;
        wr_addr_s = ext_wr_addr;
        wr_data_s = ext_wr_data;
      end
      WRITE: begin
        wr_en_s   = 1'b1;
        wr_addr_s = rd_q;
        wr_data_s = alu_Out;
      end
      default: begin
        wr_en_s   = 1'b0;
        wr_addr_s = {AW{1'b0}};
        wr_data_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Register file storage; writes aimed at r0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        rf_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s && (wr_addr_s != {AW{1'b0}})) begin
      rf_q[wr_addr_s] <= wr_data_s;
    end
  end

  // Operand latch, retire/reject pulses and last-result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q  <= {DATA_W{1'b0}};
      alu_b_q  <= {DATA_W{1'b0}};
      alu_op_q <= 4'd0;
      rd_q     <= {AW{1'b0}};
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= {DATA_W{1'b0}};
      zero_q   <= 1'b0;
    end else begin
      done_q <= (state_q == WRITE);
      err_q  <= reject_s;
      if (accept_s) begin
        alu_a_q  <= rs_data_s;
        alu_b_q  <= rt_data_s;
        alu_op_q <= instr_op;
        rd_q     <= instr_rd;
      end
      if (state_q == WRITE) begin
        result_q <= alu_Out;
        zero_q   <= alu_Zero;
      end
    end
  end

  assign alu_A     = alu_a_q;
  assign alu_B     = alu_b_q;
  assign alu_Op    = alu_op_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign zero_flag = zero_q;

endmodule
